uart_mmio_responder: RTL and testbench

// - Memory-mapped UART peripheral on the core's data-memory port (addr, MemRW, funct3, shared data_WR_inout).
// - Executes stores, drives combinational load data with funct3 sign/zero extension, runs a TX FIFO, and serialises/deserialises 8N1 frames.

---
 rtl/uart_mmio_responder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_mmio_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_responder.sv
// Memory-mapped 8N1 UART on the core data-memory port: TXDATA/RXDATA/STATUS/BAUDDIV
// registers, a TX FIFO, and independent TX/RX bit-timing state machines.
module uart_mmio_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        MemRW,
    input  logic [2:0]  funct3,
    inout  wire  [31:0] data_WR_inout,
    input  logic        rx,
    output logic        tx
);

    localparam int         PW       = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(TX_DEPTH);
    localparam logic [15:0] BAUD_RST = 16'(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    function automatic logic [15:0] clamp_baud(input logic [15:0] v);
        return (v < 16'd4) ? 16'd4 : v;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    logic        sel, wr_en, rd_en;
    logic [1:0]  off;
    logic [31:0] wdata, rd_word;
    logic        unused_bits;

    assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
    assign off         = addr[3:2];
    assign wr_en       = sel && MemRW;
    assign rd_en       = sel && !MemRW;
    assign wdata       = data_WR_inout;
    assign unused_bits = ^{addr[1:0], wdata[31:16]};

    logic [15:0] baud_div;
    logic        tx_ovf, rx_ovr, frame_err, rx_valid;
    logic [7:0]  rx_data;

    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] fifo_cnt;
    logic        tx_full, tx_empty, push_req, push, tx_pop, tx_busy;

    uart_state_t tx_state, rx_state;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_shreg, rx_shreg;

    // W1C mask from a STATUS store; index 0 corresponds to STATUS bit 3
    logic [3:0]  clr;
    assign clr = (wr_en && off == 2'd2) ? wdata[6:3] : 4'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            baud_div <= BAUD_RST;
        else if (wr_en && off == 2'd3)
            baud_div <= clamp_baud(wdata[15:0]);
    end

    assign tx_full  = (fifo_cnt == DEPTH_C);
    assign tx_empty = (fifo_cnt == '0);
    assign push_req = wr_en && (off == 2'd0);
    assign push     = push_req && !tx_full;
    assign tx_busy  = (tx_state != S_IDLE);
    assign tx_pop   = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_cnt == '0));

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tx_ovf   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, tx_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            tx_ovf <= (push_req && tx_full) | (tx_ovf & ~clr[1]);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop)
            tx_shreg <= fifo_mem[rd_ptr];
        else if (tx_state == S_DATA && tx_cnt == '0)
            tx_shreg <= {1'b0, tx_shreg[7:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (tx_pop) begin
                        tx_state <= S_START;
                        tx       <= 1'b0;
                        tx_cnt   <= baud_div - 16'd1;
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= S_DATA;
                        tx       <= tx_shreg[0];
                        tx_cnt   <= baud_div - 16'd1;
                        tx_bit   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= baud_div - 16'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx     <= tx_shreg[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= baud_div - 16'd1;
                        if (tx_pop) begin
                            tx_state <= S_START;
                            tx       <= 1'b0;
                        end else begin
                            tx_state <= S_IDLE;
                            tx       <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // RX line: two-flop synchroniser plus one delay flop for falling-edge detection
    logic rx_s1, rx_s2, rx_d, rx_fall;
    logic rx_stop_evt, rx_latch, rx_drop, rx_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall     = rx_d && !rx_s2;
    assign rx_stop_evt = (rx_state == S_STOP) && (rx_cnt == '0);
    assign rx_latch    = rx_stop_evt && rx_s2 && !rx_valid;
    assign rx_drop     = rx_stop_evt && rx_s2 && rx_valid;
    assign rx_ferr     = rx_stop_evt && !rx_s2;

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_cnt == '0)
            rx_shreg <= {rx_s2, rx_shreg[7:1]};
        if (rx_latch)
            rx_data <= rx_shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= rx_latch | (rx_valid & ~clr[0]);
            rx_ovr    <= rx_drop  | (rx_ovr & ~clr[2]);
            frame_err <= rx_ferr  | (frame_err & ~clr[3]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= S_START;
                        rx_cnt   <= (baud_div >> 1) - 16'd1;
                    end
                end
                S_START: begin
                    if (rx_cnt == '0) begin
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                        rx_cnt   <= baud_div - 16'd1;
                        rx_bit   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_cnt <= baud_div - 16'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= S_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == '0)
                        rx_state <= S_IDLE;
                    else
                        rx_cnt <= rx_cnt - 16'd1;
                end
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        case (off)
            2'd1:    rd_word = {24'b0, rx_data};
            2'd2:    rd_word = {25'b0, frame_err, rx_ovr, tx_ovf, rx_valid, tx_busy, tx_full, tx_empty};
            2'd3:    rd_word = {16'b0, baud_div};
            default: rd_word = '0;
        endcase
    end

    assign data_WR_inout = rd_en ? extend_load(funct3, rd_word) : {32{1'bz}};

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed bench for uart_mmio_responder at 16 clocks per bit; an undriven bus
// floats to all-ones through the pulled-up net.
module tb_uart_mmio_responder;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk, rst, MemRW, rx, tx, bus_oe;
    logic [31:0] addr, bus_drv;
    logic [2:0]  funct3;
    tri1  [31:0] data_bus;

    int n_vec = 0;
    int n_err = 0;

    assign data_bus = bus_oe ? bus_drv : {32{1'bz}};

    uart_mmio_responder #(
        .BASE_ADDR(32'h0000_1000),
        .CLKS_PER_BIT(16),
        .TX_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .MemRW(MemRW),
        .funct3(funct3),
        .data_WR_inout(data_bus),
        .rx(rx),
        .tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] exp);
        addr   = a;
        funct3 = f3;
        MemRW  = 1'b0;
        bus_oe = 1'b0;
        #1;
        chk(tag, data_bus, exp);
        addr   = 32'h0;
        funct3 = LW;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        MemRW   = 1'b1;
        bus_drv = d;
        bus_oe  = 1'b1;
        tick();
        MemRW   = 1'b0;
        bus_oe  = 1'b0;
        addr    = 32'h0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) tick();
        end
        rx = stop_bit;
        repeat (16) tick();
        rx = 1'b1;
        repeat (4) tick();
    endtask

    logic [7:0] burst [6];
    logic [7:0] cur;
    logic       exp_bit;

    initial begin
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
        rst = 1'b1; addr = 32'h0; MemRW = 1'b0; funct3 = LW;
        rx = 1'b1; bus_drv = 32'h0; bus_oe = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("reset_tx", {31'b0, tx}, 32'h1);
        rd_chk("reset_status", 32'h0000_1008, LW, 32'h0000_0001);
        rd_chk("reset_bauddiv", 32'h0000_100C, LW, 32'h0000_0010);
        rd_chk("load_outside_window", 32'h0000_2008, LW, 32'hFFFF_FFFF);
        rd_chk("txdata_reads_zero", 32'h0000_1000, LW, 32'h0000_0000);

        addr = 32'h0000_1004; MemRW = 1'b1; bus_oe = 1'b0;
        #1;
        chk("memrw_in_window_no_drive", data_bus, 32'hFFFF_FFFF);
        MemRW = 1'b0; addr = 32'h0;

        wr(32'h2000_100C, 32'h5);
        rd_chk("store_outside_window", 32'h0000_100C, LW, 32'h0000_0010);
        wr(32'h0000_100C, 32'h3);
        rd_chk("baud_clamp", 32'h0000_100C, LW, 32'h0000_0004);
        wr(32'h0000_100F, 32'hABCD_8001);
        rd_chk("baud_lh", 32'h0000_100C, LH, 32'hFFFF_8001);
        rd_chk("baud_lhu", 32'h0000_100C, LHU, 32'h0000_8001);
        rd_chk("baud_lb", 32'h0000_100C, LB, 32'h0000_0001);
        rd_chk("baud_f3_011_as_lw", 32'h0000_100C, 3'b011, 32'h0000_8001);
        wr(32'h0000_100C, 32'd16);
        rd_chk("baud_restore", 32'h0000_100C, LW, 32'h0000_0010);

        // single frame 0x55
        wr(32'h0000_1000, 32'h55);
        chk("tx_idle_at_push_edge", {31'b0, tx}, 32'h1);
        tick();
        chk("tx_start_latency", {31'b0, tx}, 32'h0);
        cur = 8'h55;
        for (int b = 0; b < 10; b++) begin
            repeat (8) tick();
            exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
            chk($sformatf("tx55_bit%0d", b), {31'b0, tx}, {31'b0, exp_bit});
            if (b == 4)
                rd_chk("status_busy_mid_frame", 32'h0000_1008, LW, 32'h0000_0005);
            repeat (8) tick();
        end
        chk("tx55_idle_after", {31'b0, tx}, 32'h1);
        rd_chk("status_after_frame", 32'h0000_1008, LW, 32'h0000_0001);

        // six back-to-back pushes: five frames, one overflow
        for (int k = 0; k < 6; k++)
            wr(32'h0000_1000, {24'b0, burst[k]});
        rd_chk("status_full_ovf", 32'h0000_1008, LW, 32'h0000_0016);
        repeat (4) tick();
        for (int f = 0; f < 5; f++) begin
            cur = burst[f];
            for (int b = 0; b < 10; b++) begin
                exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
                chk($sformatf("burst_f%0d_bit%0d", f, b), {31'b0, tx}, {31'b0, exp_bit});
                repeat (16) tick();
            end
        end
        rd_chk("status_burst_done", 32'h0000_1008, LW, 32'h0000_0011);
        wr(32'h0000_1008, 32'h10);
        rd_chk("clear_tx_ovf", 32'h0000_1008, LW, 32'h0000_0001);

        // receive path
        rx_send(8'hA5, 1'b1);
        rd_chk("rx_status_valid", 32'h0000_1008, LW, 32'h0000_0009);
        rd_chk("rx_lbu", 32'h0000_1004, LBU, 32'h0000_00A5);
        rd_chk("rx_lb", 32'h0000_1004, LB, 32'hFFFF_FFA5);
        rd_chk("rx_lw_no_side_effect", 32'h0000_1004, LW, 32'h0000_00A5);
        rx_send(8'h3C, 1'b1);
        rd_chk("rx_overrun_status", 32'h0000_1008, LW, 32'h0000_0029);
        rd_chk("rx_overrun_keeps_old", 32'h0000_1004, LW, 32'h0000_00A5);
        wr(32'h0000_1008, 32'h28);
        rd_chk("rx_clear_valid_ovr", 32'h0000_1008, LW, 32'h0000_0001);
        rx_send(8'h5A, 1'b0);
        rd_chk("rx_frame_err", 32'h0000_1008, LW, 32'h0000_0041);
        rd_chk("rx_frame_err_no_latch", 32'h0000_1004, LW, 32'h0000_00A5);
        wr(32'h0000_1008, 32'h47);
        rd_chk("clear_frame_err", 32'h0000_1008, LW, 32'h0000_0001);
        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        repeat (40) tick();
        rd_chk("rx_glitch_status", 32'h0000_1008, LW, 32'h0000_0001);
        rd_chk("rx_glitch_data", 32'h0000_1004, LW, 32'h0000_00A5);

        // asynchronous reset in the middle of a frame
        wr(32'h0000_1000, 32'h00);
        tick();
        repeat (20) tick();
        chk("tx_low_before_reset", {31'b0, tx}, 32'h0);
        rst = 1'b1;
        #1;
        chk("async_reset_tx", {31'b0, tx}, 32'h1);
        rd_chk("async_reset_status", 32'h0000_1008, LW, 32'h0000_0001);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("post_reset_tx_idle", {31'b0, tx}, 32'h1);
        rd_chk("post_reset_status", 32'h0000_1008, LW, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
